// File: rtl/ifetch_queue_pkg.sv
// Shared constants for the instruction-fetch queue.
//   INSTR_W   : instruction word width
//   ADDR_W    : default fetch-address width
//   DEPTH     : default number of queue entries
//   NOP_INSTR : word presented on instr_out while the queue is empty
package ifetch_queue_pkg;
   localparam int          INSTR_W   = 32;
   localparam int          ADDR_W    = 8;
   localparam int          DEPTH     = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/ifetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x W, one write port, one
// asynchronous read port. Contents are not reset; the control logic
// masks stale entries with valid.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : read data (combinational)
module ifetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 40,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  logic [W-1:0]     wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output logic [W-1:0]     rdata_o
);
   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: fetches from a combinational ROM at fpc, buffers
// {instr, pc+4} entries in FIFO order, and hands the head to decode.
//   clk         : clock
//   R           : async active-low reset
//   rom_addr    : fetch address to ROM (= fpc)
//   rom_data    : ROM word for rom_addr
//   branch      : redirect, flushes queue and loads target_addr into fpc
//   target_addr : redirect address
//   deq_en      : decode accepts head entry
//   instr_out   : head instruction (NOP when empty)
//   pc_plus_4   : head fetch address + 4 (0 when empty)
//   valid       : head present
//   count       : occupied entries
module ifetch_queue #(
   parameter int DEPTH  = ifetch_queue_pkg::DEPTH,
   parameter int ADDR_W = ifetch_queue_pkg::ADDR_W
) (
   input  logic                     clk,
   input  logic                     R,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [31:0]              rom_data,
   input  logic                     branch,
   input  logic [ADDR_W-1:0]        target_addr,
   input  logic                     deq_en,
   output logic [31:0]              instr_out,
   output logic [ADDR_W-1:0]        pc_plus_4,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);
   import ifetch_queue_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = INSTR_W + ADDR_W;

   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ENT_W-1:0]  rdata;
   logic [ADDR_W-1:0] fpc_inc;
   logic              full, enq, deq;

   assign fpc_inc = fpc_q + ADDR_W'(4);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign valid   = (count_q != '0);
   // Branch wins over both ports; a full queue may still enqueue into the
   // slot freed by a same-cycle dequeue.
   assign deq     = valid && deq_en && !branch;
   assign enq     = !branch && (!full || deq);

   always_comb begin
      fpc_d   = fpc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (branch) begin
         fpc_d   = target_addr;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) begin
            fpc_d  = fpc_inc;
            tail_d = tail_q + PTR_W'(1);
         end
         if (deq) head_d = head_q + PTR_W'(1);
         if (enq && !deq)      count_d = count_q + CNT_W'(1);
         else if (deq && !enq) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         fpc_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         fpc_q   <= fpc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   ifetch_queue_mem #(.DEPTH(DEPTH), .W(ENT_W)) u_mem (
      .clk     (clk),
      .we_i    (enq),
      .waddr_i (tail_q),
      .wdata_i ({rom_data, fpc_inc}),
      .raddr_i (head_q),
      .rdata_o (rdata)
   );

   assign rom_addr  = fpc_q;
   assign count     = count_q;
   assign instr_out = valid ? rdata[ENT_W-1 -: INSTR_W] : NOP_INSTR;
   assign pc_plus_4 = valid ? rdata[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
   logic        clk = 1'b0;
   logic        R;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;
   logic        branch;
   logic [7:0]  target_addr;
   logic        deq_en;
   logic [31:0] instr_out;
   logic [7:0]  pc_plus_4;
   logic        valid;
   logic [2:0]  count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   // ROM word i lives at byte address 4*i.
   assign rom_data = 32'hE000_0000 + {24'h0, rom_addr} / 4;

   ifetch_queue #(.DEPTH(4), .ADDR_W(8)) dut (
      .clk         (clk),
      .R           (R),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .branch      (branch),
      .target_addr (target_addr),
      .deq_en      (deq_en),
      .instr_out   (instr_out),
      .pc_plus_4   (pc_plus_4),
      .valid       (valid),
      .count       (count)
   );

   typedef struct {
      logic        br;
      logic [7:0]  tgt;
      logic        deq;
      logic [2:0]  cnt;
      logic        vld;
      logic [31:0] ins;
      logic [7:0]  pc4;
      logic [7:0]  rom;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input logic [2:0] c, input logic v,
                          input logic [31:0] i, input logic [7:0] p, input logic [7:0] a);
      chk({tag, " count"},     {29'h0, count},     {29'h0, c});
      chk({tag, " valid"},     {31'h0, valid},     {31'h0, v});
      chk({tag, " instr_out"}, instr_out,          i);
      chk({tag, " pc_plus_4"}, {24'h0, pc_plus_4}, {24'h0, p});
      chk({tag, " rom_addr"},  {24'h0, rom_addr},  {24'h0, a});
   endtask

   initial begin
      // fill from reset, then hold when full
      vecs.push_back('{1'b0, 8'd0,   1'b0, 3'd1, 1'b1, 32'hE000_0000, 8'd4,   8'd4});
      vecs.push_back('{1'b0, 8'd0,   1'b0, 3'd2, 1'b1, 32'hE000_0000, 8'd4,   8'd8});
      vecs.push_back('{1'b0, 8'd0,   1'b0, 3'd3, 1'b1, 32'hE000_0000, 8'd4,   8'd12});
      vecs.push_back('{1'b0, 8'd0,   1'b0, 3'd4, 1'b1, 32'hE000_0000, 8'd4,   8'd16});
      vecs.push_back('{1'b0, 8'd0,   1'b0, 3'd4, 1'b1, 32'hE000_0000, 8'd4,   8'd16});
      // streaming while full
      vecs.push_back('{1'b0, 8'd0,   1'b1, 3'd4, 1'b1, 32'hE000_0001, 8'd8,   8'd20});
      vecs.push_back('{1'b0, 8'd0,   1'b1, 3'd4, 1'b1, 32'hE000_0002, 8'd12,  8'd24});
      vecs.push_back('{1'b0, 8'd0,   1'b1, 3'd4, 1'b1, 32'hE000_0003, 8'd16,  8'd28});
      vecs.push_back('{1'b0, 8'd0,   1'b1, 3'd4, 1'b1, 32'hE000_0004, 8'd20,  8'd32});
      vecs.push_back('{1'b0, 8'd0,   1'b1, 3'd4, 1'b1, 32'hE000_0005, 8'd24,  8'd36});
      vecs.push_back('{1'b0, 8'd0,   1'b1, 3'd4, 1'b1, 32'hE000_0006, 8'd28,  8'd40});
      // redirect to 100, fill to 3, then flush to 40 (deq_en=1 ignored)
      vecs.push_back('{1'b1, 8'd100, 1'b0, 3'd0, 1'b0, 32'h0,         8'd0,   8'd100});
      vecs.push_back('{1'b0, 8'd0,   1'b0, 3'd1, 1'b1, 32'hE000_0019, 8'd104, 8'd104});
      vecs.push_back('{1'b0, 8'd0,   1'b0, 3'd2, 1'b1, 32'hE000_0019, 8'd104, 8'd108});
      vecs.push_back('{1'b0, 8'd0,   1'b0, 3'd3, 1'b1, 32'hE000_0019, 8'd104, 8'd112});
      vecs.push_back('{1'b1, 8'd40,  1'b1, 3'd0, 1'b0, 32'h0,         8'd0,   8'd40});
      vecs.push_back('{1'b0, 8'd0,   1'b0, 3'd1, 1'b1, 32'hE000_000A, 8'd44,  8'd44});
      // wrap: redirect to 252, then empty dequeue and streaming across 0
      vecs.push_back('{1'b1, 8'd252, 1'b1, 3'd0, 1'b0, 32'h0,         8'd0,   8'd252});
      vecs.push_back('{1'b0, 8'd0,   1'b1, 3'd1, 1'b1, 32'hE000_003F, 8'd0,   8'd0});
      vecs.push_back('{1'b0, 8'd0,   1'b1, 3'd1, 1'b1, 32'hE000_0000, 8'd4,   8'd4});
      vecs.push_back('{1'b0, 8'd0,   1'b1, 3'd1, 1'b1, 32'hE000_0001, 8'd8,   8'd8});

      R = 1'b0; branch = 1'b0; target_addr = '0; deq_en = 1'b0;
      #1;
      chk_all("reset", 3'd0, 1'b0, 32'h0, 8'd0, 8'd0);
      #1 R = 1'b1;

      foreach (vecs[k]) begin
         branch      = vecs[k].br;
         target_addr = vecs[k].tgt;
         deq_en      = vecs[k].deq;
         @(posedge clk); #2;
         chk_all($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].vld,
                 vecs[k].ins, vecs[k].pc4, vecs[k].rom);
      end

      // async reset mid-cycle with two entries queued
      branch = 1'b0; deq_en = 1'b0;
      @(posedge clk); #2;
      chk_all("pre_rst", 3'd2, 1'b1, 32'hE000_0001, 8'd8, 8'd12);
      R = 1'b0;
      #1;
      chk_all("async_rst", 3'd0, 1'b0, 32'h0, 8'd0, 8'd0);
      @(posedge clk); #2;
      chk_all("rst_hold", 3'd0, 1'b0, 32'h0, 8'd0, 8'd0);
      R = 1'b1;
      @(posedge clk); #2;
      chk_all("rst_release", 3'd1, 1'b1, 32'hE000_0000, 8'd4, 8'd4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, the number of queue entries (power of two, 2..8).
REQ-002 The module SHALL have parameter ADDR_W, default 8, the fetch-address width.
REQ-003 clk  input  1  clock; every register updates on the rising edge.
REQ-004 R  input  1  reset; asynchronous, active-low (R=0 resets the block).
REQ-005 rom_addr  output  ADDR_W  fetch address driven to the combinational instruction ROM.
REQ-006 rom_data  input  32  instruction returned by the ROM in the same cycle for rom_addr.
REQ-007 branch  input  1  redirect request from the condition handler.
REQ-008 target_addr  input  ADDR_W  redirect address, valid when branch=1.
REQ-009 deq_en  input  1  the decode-stage register accepts the head entry this cycle (the hazard-unit load enable).
REQ-010 instr_out  output  32  head-entry instruction.
REQ-011 pc_plus_4  output  ADDR_W  head-entry fetch address + 4.
REQ-012 valid  output  1  head entry is present.
REQ-013 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 The block SHALL hold the fetch PC register fpc, and rom_addr SHALL equal fpc combinationally.
REQ-015 An enqueue SHALL occur when branch=0 and either (count<DEPTH) or (count=DEPTH and a dequeue occurs in the same cycle).
REQ-016 On an enqueue, the tail SHALL write {rom_data, fpc+4}, and fpc SHALL become fpc+4 (modulo 2^ADDR_W, so 252 -> 0 with ADDR_W=8).
REQ-017 When count=DEPTH and no dequeue occurs, the block SHALL not enqueue, and fpc SHALL hold.
REQ-018 A dequeue SHALL occur when valid=1, deq_en=1 and branch=0, and it SHALL advance the head pointer.
REQ-019 deq_en=1 while count=0 SHALL have no effect; there is no bypass from rom_data to instr_out.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-021 Otherwise, count SHALL change by +1 on an enqueue only and by -1 on a dequeue only.
REQ-022 branch=1 SHALL take priority over everything else. On that edge, count, head and tail SHALL go to 0, fpc SHALL load target_addr, nothing is enqueued, and nothing is dequeued.
REQ-023 After a branch, the first target instruction SHALL be visible (valid=1) one edge after the redirect edge.
REQ-024 valid SHALL equal (count!=0).
REQ-025 instr_out and pc_plus_4 SHALL show the head-entry contents.
REQ-026 When valid=0, instr_out SHALL be 32'h0 (NOP) and pc_plus_4 SHALL be 0.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-028 Entry order SHALL be strict FIFO.
REQ-029 Fetch-to-visible latency SHALL be 1 clock: data fetched at edge n is at the head, if the queue was empty, after edge n.

Reset
REQ-030 While R=0, fpc SHALL be 0, head and tail SHALL be 0, count SHALL be 0, valid SHALL be 0, and instr_out and pc_plus_4 SHALL be 0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately.
REQ-032 The first edge with R=1 SHALL enqueue the ROM word at address 0.
REQ-033 Storage-array contents SHALL need no reset, because they are masked by valid.

Structure
REQ-034 A shared package SHALL hold constants INSTR_W=32, ADDR_W=8, DEPTH=4 and NOP_INSTR=32'h0.
REQ-035 The storage SHALL be one sub-module, ifetch_queue_mem: DEPTH x (32+ADDR_W), one write port, one asynchronous read port.
REQ-036 Pointer, count and fpc control SHALL live in ifetch_queue.

Verification
REQ-037 Scenario (reset then fill): ROM[i] = 32'hE000_0000 + i; release R with deq_en=0 -> after 4 edges count=4, head instr = 32'hE000_0000, pc_plus_4=4, rom_addr=16, and rom_addr holds at 16.
REQ-038 Scenario (streaming): from full, hold deq_en=1 for 6 edges -> count stays 4, and instr_out steps through 32'hE000_0000..32'hE000_0005 in order.
REQ-039 Scenario (flush): branch=1 with target_addr=40 while count=3 -> next edge count=0, valid=0, rom_addr=40; following edge instr_out = ROM word at 40, pc_plus_4=44.
REQ-040 Scenario (wrap-around): branch to 252 with deq_en=1 -> pc_plus_4 sequence is 0, 4, 8, and rom_addr wraps 252 -> 0.
REQ-041 Scenario (empty dequeue): count=0 with deq_en=1 and branch=0 -> count becomes 1, not underflow, and instr_out=0 before the edge.
REQ-042 Scenario (async reset): drive R=0 between clock edges while count=2 -> valid=0, count=0 and rom_addr=0 at once; after release, the first fetched word is ROM[0].
